bram_bank_loader: RTL and testbench



---
 rtl/parsing_ctrl_pkg.sv | 26 ++
 rtl/bram_bank_loader_if.sv | 22 ++
 rtl/bank_addr_counter.sv | 55 +++++
 rtl/bram_bank_loader.sv | 120 ++++++++++++
 tb/tb_bram_bank_loader.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parsing_ctrl_pkg.sv
// Shared constants and loader state encoding for the
// feature-map BRAM write path.
package parsing_ctrl_pkg;

  localparam int NUM_BANK = 16;
  localparam int BANK_AW  = 4;
  localparam int AW       = 9;
  localparam int DW       = 128;
  localparam int DEPTH    = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_START,
    ST_DONE
  } ld_state_e;

  function automatic logic [NUM_BANK-1:0] bank_onehot(
    input logic [BANK_AW-1:0] b
  );
    bank_onehot    = '0;
    bank_onehot[b] = 1'b1;
  endfunction

endpackage

// File: rtl/bram_bank_loader_if.sv
// Stream handshake into the loader: 128-bit words
// with valid/ready.
interface bram_bank_loader_if;
  import parsing_ctrl_pkg::*;

  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/bank_addr_counter.sv
// Bank-interleaved position counter: bank cycles 0..15,
// addr advances on each bank wrap, last flags word N*16-1.
module bank_addr_counter
  import parsing_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [AW:0]        n_i,
  output logic [BANK_AW-1:0] bank_o,
  output logic [AW-1:0]      addr_o,
  output logic               last_o
);

  logic [BANK_AW-1:0] bank_q, bank_d;
  logic [AW-1:0]      addr_q, addr_d;

  assign bank_o = bank_q;
  assign addr_o = addr_q;
  assign last_o = (bank_q == BANK_AW'(NUM_BANK-1))
               && ({1'b0, addr_q} == n_i - 1'b1);

  // Next position; the last word wraps to 0 so a full
  // 512-deep load never steps past address 511.
  always_comb begin
    bank_d = bank_q;
    addr_d = addr_q;
    if (clr_i) begin
      bank_d = '0;
      addr_d = '0;
    end else if (inc_i) begin
      if (last_o) begin
        bank_d = '0;
        addr_d = '0;
      end else begin
        bank_d = bank_q + 1'b1;
        if (bank_q == BANK_AW'(NUM_BANK-1))
          addr_d = addr_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_q <= '0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/bram_bank_loader.sv
// Scatters a word stream across 16 BRAM banks, then
// pulses the parser start once the last write commits.
module bram_bank_loader
  import parsing_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_load_start,
  input  logic [AW:0]         i_words_per_bank,
  input  logic                i_abort,
  bram_bank_loader_if.slave   s_if,
  output logic [NUM_BANK-1:0] o_ena,
  output logic [NUM_BANK-1:0] o_wea,
  output logic [AW-1:0]       o_addra,
  output logic [DW-1:0]       o_dia,
  output logic                o_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  ld_state_e           state_q;
  logic [AW:0]         n_q;
  logic [NUM_BANK-1:0] wen_q;
  logic [AW-1:0]       addra_q;
  logic [DW-1:0]       dia_q;
  logic                err_q;

  logic [BANK_AW-1:0]  bank;
  logic [AW-1:0]       addr;
  logic                last;
  logic                req_ok;
  logic                idle_like;
  logic                cnt_clr;
  logic                cnt_inc;

  assign req_ok    = (i_words_per_bank != '0)
                  && (i_words_per_bank <= (AW+1)'(DEPTH));
  assign idle_like = (state_q == ST_IDLE)
                  || (state_q == ST_DONE);
  assign cnt_clr   = i_abort
                  || (idle_like && i_load_start && req_ok);
  assign cnt_inc   = (state_q == ST_LOAD) && s_if.valid
                  && !i_abort;

  assign s_if.ready = (state_q == ST_LOAD);

  assign o_ena   = wen_q;
  assign o_wea   = wen_q;
  assign o_addra = addra_q;
  assign o_dia   = dia_q;
  assign o_err   = err_q;
  assign o_start = (state_q == ST_START);
  assign o_done  = (state_q == ST_DONE);
  assign o_busy  = (state_q == ST_LOAD)
                || (state_q == ST_FLUSH);

  bank_addr_counter u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .n_i    (n_q),
    .bank_o (bank),
    .addr_o (addr),
    .last_o (last)
  );

  // Loader FSM with registered write port; abort
  // overrides everything, including a same-cycle request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      wen_q   <= '0;
      addra_q <= '0;
      dia_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wen_q <= '0;
      err_q <= 1'b0;
      if (i_abort) begin
        state_q <= ST_IDLE;
      end else begin
        if (cnt_inc) begin
          wen_q   <= bank_onehot(bank);
          addra_q <= addr;
          dia_q   <= s_if.data;
        end
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (i_load_start) begin
              if (req_ok) begin
                state_q <= ST_LOAD;
                n_q     <= i_words_per_bank;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            err_q <= i_load_start;
            if (cnt_inc && last)
              state_q <= ST_FLUSH;
          end
          ST_FLUSH: begin
            err_q   <= i_load_start;
            state_q <= ST_START;
          end
          ST_START: begin
            err_q   <= i_load_start;
            state_q <= ST_DONE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_bank_loader.sv
// Directed bench for bram_bank_loader: interleave,
// gaps, full depth, abort, bad requests, reset.
module tb_bram_bank_loader;
  import parsing_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rstn = 1'b1;
  logic                i_load_start = 1'b0;
  logic                i_abort = 1'b0;
  logic [AW:0]         i_words_per_bank = '0;
  logic [NUM_BANK-1:0] o_ena, o_wea;
  logic [AW-1:0]       o_addra;
  logic [DW-1:0]       o_dia;
  logic                o_start, o_busy, o_done, o_err;

  int errors = 0;
  int checks = 0;
  int wea_cnt = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] mem [0:8191];

  bram_bank_loader_if sif();

  always #5 clk = ~clk;

  bram_bank_loader dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_load_start     (i_load_start),
    .i_words_per_bank (i_words_per_bank),
    .i_abort          (i_abort),
    .s_if             (sif),
    .o_ena            (o_ena),
    .o_wea            (o_wea),
    .o_addra          (o_addra),
    .o_dia            (o_dia),
    .o_start          (o_start),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err)
  );

  // Shadow BRAM and pulse counters.
  always @(negedge clk) begin
    if (rstn) begin
      wea_cnt   += $countones(o_wea);
      start_cnt += int'(o_start);
      err_cnt   += int'(o_err);
      for (int b = 0; b < NUM_BANK; b++)
        if (o_wea[b])
          mem[b*512 + int'(o_addra)] = o_dia;
    end
  end

  function automatic logic [DW-1:0] d_of(input int k);
    d_of = {32'(k), ~32'(k),
            32'hC0DE_0000 ^ 32'(k), 32'(k*7+1)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int n);
    i_words_per_bank = (AW+1)'(n);
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #10;
    checks++;
    if ({o_ena, o_wea} !== '0 || o_addra !== '0
        || o_dia !== '0) begin
      errors++;
      $display("FAIL reset_port got ena=%h wea=%h a=%h",
               o_ena, o_wea, o_addra, " need 0");
    end
    checks++;
    if ({o_start, o_busy, o_done, o_err, sif.ready}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b need 00000",
               {o_start, o_busy, o_done, o_err, sif.ready});
    end
    @(negedge clk) rstn = 1'b1;
    step();
    checks++;
    if (o_busy !== 1'b0 || sif.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b rdy=%b need 0 0",
               o_busy, sif.ready);
    end
  endtask

  task automatic test_n1();
    int wb = wea_cnt;
    int sb = start_cnt;
    start_load(1);
    checks++;
    if (sif.ready !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL n1_enter rdy=%b busy=%b need 1 1",
               sif.ready, o_busy);
    end
    for (int k = 0; k < 16; k++) begin
      sif.valid = 1'b1;
      sif.data  = d_of(k);
      step();
      checks++;
      if (o_wea !== 16'(1 << k) || o_ena !== 16'(1 << k)
          || o_addra !== '0 || o_dia !== d_of(k)) begin
        errors++;
        $display("FAIL n1_wr k=%0d wea=%h a=%h need %h 0",
                 k, o_wea, o_addra, 16'(1 << k));
      end
    end
    sif.valid = 1'b0;
    checks++;
    if (o_start !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL n1_flush start=%b busy=%b need 0 1",
               o_start, o_busy);
    end
    step();
    checks++;
    if (o_start !== 1'b1) begin
      errors++;
      $display("FAIL n1_start got %b need 1", o_start);
    end
    step();
    checks++;
    if (o_start !== 1'b0 || o_done !== 1'b1
        || o_busy !== 1'b0 || sif.ready !== 1'b0) begin
      errors++;
      $display("FAIL n1_done s=%b d=%b b=%b need 0 1 0",
               o_start, o_done, o_busy);
    end
    step();
    checks++;
    if (wea_cnt - wb != 16 || start_cnt - sb != 1) begin
      errors++;
      $display("FAIL n1_count wea=%0d st=%0d need 16 1",
               wea_cnt - wb, start_cnt - sb);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (mem[k*512] !== d_of(k)) begin
        errors++;
        $display("FAIL n1_mem bank=%0d got %h need %h",
                 k, mem[k*512], d_of(k));
      end
    end
  endtask

  task automatic test_n2_gaps();
    int wb = wea_cnt;
    int sb = start_cnt;
    start_load(2);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL n2_enter done=%b busy=%b need 0 1",
               o_done, o_busy);
    end
    for (int k = 0; k < 32; k++) begin
      sif.valid = 1'b1;
      sif.data  = d_of(k + 100);
      step();
      checks++;
      if (o_wea !== 16'(1 << (k % 16))
          || o_addra !== AW'(k / 16)
          || o_dia !== d_of(k + 100)) begin
        errors++;
        $display("FAIL n2_wr k=%0d wea=%h a=%0d", k,
                 o_wea, o_addra);
      end
      sif.valid = 1'b0;
      step();
      checks++;
      if (o_wea !== '0
          || o_start !== ((k == 31) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL n2_gap k=%0d wea=%h start=%b",
                 k, o_wea, o_start);
      end
    end
    step();
    step();
    checks++;
    if (wea_cnt - wb != 32 || start_cnt - sb != 1) begin
      errors++;
      $display("FAIL n2_count wea=%0d st=%0d need 32 1",
               wea_cnt - wb, start_cnt - sb);
    end
    checks++;
    if (mem[1*512 + 1] !== d_of(117)) begin
      errors++;
      $display("FAIL n2_word17 got %h need %h",
               mem[513], d_of(117));
    end
  endtask

  task automatic test_n512();
    int wb = wea_cnt;
    int sb = start_cnt;
    start_load(512);
    sif.valid = 1'b1;
    for (int k = 0; k < 8192; k++) begin
      sif.data = d_of(k + 1000);
      step();
    end
    sif.valid = 1'b0;
    checks++;
    if (o_wea !== 16'h8000 || o_addra !== 9'd511
        || o_dia !== d_of(9191)) begin
      errors++;
      $display("FAIL n512_last wea=%h a=%0d need 8000 511",
               o_wea, o_addra);
    end
    checks++;
    if (dut.u_cnt.bank_o !== '0
        || dut.u_cnt.addr_o !== '0) begin
      errors++;
      $display("FAIL n512_wrap bank=%0d addr=%0d need 0 0",
               dut.u_cnt.bank_o, dut.u_cnt.addr_o);
    end
    step();
    checks++;
    if (o_start !== 1'b1) begin
      errors++;
      $display("FAIL n512_start got %b need 1", o_start);
    end
    step();
    step();
    checks++;
    if (wea_cnt - wb != 8192 || start_cnt - sb != 1) begin
      errors++;
      $display("FAIL n512_count wea=%0d st=%0d",
               wea_cnt - wb, start_cnt - sb);
    end
    checks++;
    if (mem[15*512 + 511] !== d_of(9191)
        || mem[3*512 + 100] !== d_of(1603 + 1000)) begin
      errors++;
      $display("FAIL n512_mem got %h need %h",
               mem[15*512 + 511], d_of(9191));
    end
  endtask

  task automatic test_abort();
    int sb = start_cnt;
    int eb = err_cnt;
    start_load(4);
    sif.valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      sif.data = d_of(k + 20000);
      step();
    end
    checks++;
    if (o_wea !== 16'h0008 || o_addra !== 9'd1) begin
      errors++;
      $display("FAIL ab_w19 wea=%h a=%0d need 0008 1",
               o_wea, o_addra);
    end
    sif.data = d_of(20020);
    i_abort = 1'b1;
    i_load_start = 1'b1;
    i_words_per_bank = 10'd1;
    step();
    i_abort = 1'b0;
    i_load_start = 1'b0;
    sif.valid = 1'b0;
    checks++;
    if (sif.ready !== 1'b0 || o_busy !== 1'b0
        || o_wea !== '0 || o_done !== 1'b0
        || o_err !== 1'b0) begin
      errors++;
      $display("FAIL ab_idle r=%b b=%b w=%h d=%b e=%b",
               sif.ready, o_busy, o_wea, o_done, o_err);
    end
    step();
    step();
    checks++;
    if (start_cnt - sb != 0 || err_cnt - eb != 0
        || o_done !== 1'b0) begin
      errors++;
      $display("FAIL ab_quiet st=%0d err=%0d done=%b",
               start_cnt - sb, err_cnt - eb, o_done);
    end
    start_load(1);
    for (int k = 0; k < 16; k++) begin
      sif.valid = 1'b1;
      sif.data  = d_of(k + 300);
      step();
      if (k == 0) begin
        checks++;
        if (o_wea !== 16'h0001 || o_addra !== '0) begin
          errors++;
          $display("FAIL ab_reload wea=%h a=%0d need 1 0",
                   o_wea, o_addra);
        end
      end
    end
    sif.valid = 1'b0;
    step();
    checks++;
    if (o_start !== 1'b1) begin
      errors++;
      $display("FAIL ab_start got %b need 1", o_start);
    end
    step();
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL ab_done got %b need 1", o_done);
    end
  endtask

  task automatic test_bad_n();
    int eb;
    int wb;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    eb = err_cnt;
    wb = wea_cnt;
    for (int t = 0; t < 2; t++) begin
      i_words_per_bank = (t == 0) ? 10'd0 : 10'd513;
      i_load_start = 1'b1;
      step();
      i_load_start = 1'b0;
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0
          || sif.ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_req t=%0d err=%b busy=%b",
                 t, o_err, o_busy);
      end
      step();
      checks++;
      if (o_err !== 1'b0) begin
        errors++;
        $display("FAIL bad_pulse t=%0d err=%b need 0",
                 t, o_err);
      end
    end
    step();
    checks++;
    if (err_cnt - eb != 2 || wea_cnt - wb != 0
        || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL bad_total err=%0d wea=%0d need 2 0",
               err_cnt - eb, wea_cnt - wb);
    end
  endtask

  task automatic test_start_during_load();
    start_load(1);
    for (int k = 0; k < 16; k++) begin
      sif.valid = 1'b1;
      sif.data  = d_of(k + 400);
      if (k == 5) begin
        i_load_start = 1'b1;
        i_words_per_bank = 10'd2;
      end
      step();
      i_load_start = 1'b0;
      if (k == 5) begin
        checks++;
        if (o_err !== 1'b1 || o_wea !== 16'h0020) begin
          errors++;
          $display("FAIL sdl_err err=%b wea=%h need 1 0020",
                   o_err, o_wea);
        end
      end
    end
    sif.valid = 1'b0;
    step();
    checks++;
    if (o_start !== 1'b1) begin
      errors++;
      $display("FAIL sdl_start got %b need 1", o_start);
    end
    step();
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL sdl_done got %b need 1", o_done);
    end
  endtask

  task automatic test_reset_mid_load();
    start_load(1);
    sif.valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sif.data = d_of(k + 500);
      step();
    end
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({o_ena, o_wea} !== '0 || o_addra !== '0
        || o_dia !== '0) begin
      errors++;
      $display("FAIL rst_port wea=%h a=%h need 0 0",
               o_wea, o_addra);
    end
    checks++;
    if ({o_start, o_busy, o_done, o_err, sif.ready}
        !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags got %b need 00000",
               {o_start, o_busy, o_done, o_err, sif.ready});
    end
    sif.valid = 1'b0;
    @(negedge clk) rstn = 1'b1;
    step();
    checks++;
    if (o_busy !== 1'b0 || o_wea !== '0) begin
      errors++;
      $display("FAIL rst_after busy=%b wea=%h need 0 0",
               o_busy, o_wea);
    end
  endtask

  initial begin
    sif.valid = 1'b0;
    sif.data  = '0;
    test_reset();
    test_n1();
    test_n2_gaps();
    test_n512();
    test_abort();
    test_bad_n();
    test_start_during_load();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
